// File: rtl/piso_stream.sv
`default_nettype none
// ============================================================================
// Module   : piso_stream
// Purpose  : Parallel-in/serial-out shifter with a valid/ready word load,
//            per-word LSB/MSB-first selection and a stallable serial output.
// Revision : 1.0 - initial release
// ============================================================================
module piso_stream #(
  parameter int unsigned WIDTH      = 4,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] din,
  input  logic             msb_first,
  input  logic             shift_en,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             dir_q,   dir_d;

  logic             in_shift;
  logic             at_last;
  logic             accept;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      count_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    in_shift   = (state_q == SHIFT);
    at_last    = in_shift && (count_q == CNT_LAST);
    // Ready during the final consumed bit lets the next word follow with no bubble.
    load_ready = !in_shift || (at_last && shift_en);
    accept     = load_valid && load_ready;

    state_d = state_q;
    shreg_d = shreg_q;
    count_d = count_q;
    dir_d   = dir_q;

    if (accept) begin
      state_d = SHIFT;
      shreg_d = din;
      dir_d   = msb_first;
      count_d = '0;
    end else if (in_shift && shift_en) begin
      if (dir_q) begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      end else begin
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      end
      if (at_last) begin
        state_d = IDLE;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end

    sout_valid = in_shift;
    busy       = in_shift;
    last       = at_last;
    sout       = in_shift ? (dir_q ? shreg_q[WIDTH-1] : shreg_q[0]) : IDLE_LEVEL;
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_piso_stream
// Purpose  : Scoreboard bench for piso_stream at widths 4, 8, 2, 5 and 16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_piso_stream;

  localparam int N_DUT = 5;

  function automatic int w_of(input int i);
    case (i)
      0:       return 4;
      1:       return 8;
      2:       return 2;
      3:       return 5;
      default: return 16;
    endcase
  endfunction

  function automatic logic il_of(input int i);
    return (i == 3) ? 1'b1 : 1'b0;
  endfunction

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sen = 1'b0;
  logic        lv    [N_DUT];
  logic        msb_a [N_DUT];
  logic [15:0] din_a [N_DUT];
  logic        lr    [N_DUT];
  logic        so    [N_DUT];
  logic        sv    [N_DUT];
  logic        la    [N_DUT];
  logic        bz    [N_DUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    piso_stream #(
      .WIDTH      (w_of(g)),
      .IDLE_LEVEL (il_of(g))
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .load_valid (lv[g]),
      .load_ready (lr[g]),
      .din        (din_a[g][w_of(g)-1:0]),
      .msb_first  (msb_a[g]),
      .shift_en   (sen),
      .sout       (so[g]),
      .sout_valid (sv[g]),
      .last       (la[g]),
      .busy       (bz[g])
    );
  end

  int n_checks = 0;
  int n_err    = 0;
  int act      = 0;
  int consumed = 0;
  bit mon_on   = 1'b0;
  bit rnd_stall = 1'b0;
  bit sen_dir  = 1'b1;
  bit exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s (dut %0d) got %0h expected %0h at %0t", tag, act, got, exp, $time);
    end
  endtask

  // Shift-enable source: random stalls in regression, directed value otherwise.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      sen = rnd_stall ? ($urandom_range(0, 3) != 0) : sen_dir;
    end
  end

  // Monitor: compare the active DUT against the expected-bit queue every cycle.
  initial begin
    int  n;
    logic e_so;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        n    = exp_q.size();
        e_so = (n != 0) ? exp_q[0] : il_of(act);
        check("sout_valid", 32'(sv[act]), 32'(n != 0));
        check("busy",       32'(bz[act]), 32'(n != 0));
        check("sout",       32'(so[act]), 32'(e_so));
        check("last",       32'(la[act]), 32'(n == 1));
        check("load_ready", 32'(lr[act]), 32'((n == 0) || ((n == 1) && sen)));
        if ((n != 0) && sen) begin
          void'(exp_q.pop_front());
          consumed++;
        end
      end
    end
  end

  task automatic send_word(input logic [15:0] wrd, input logic m, input int gap);
    bit ok;
    int wd;
    wd = w_of(act);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    din_a[act] = wrd;
    msb_a[act] = m;
    lv[act]    = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (lr[act]) ok = 1'b1;
    end
    if (!ok) begin
      check("load_timeout", 32'd0, 32'd1);
      lv[act] = 1'b0;
    end else begin
      @(posedge clk);
      for (int i = 0; i < wd; i++) begin
        exp_q.push_back(m ? wrd[wd-1-i] : wrd[i]);
      end
      #1;
      lv[act] = 1'b0;
    end
  endtask

  task automatic wait_consumed(input int target);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk);
      if (consumed >= target) ok = 1'b1;
    end
    if (!ok) check("consume_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 1000 && !ok; k++) begin
      @(negedge clk);
      if ((exp_q.size() == 0) && !sv[act]) ok = 1'b1;
    end
    check("drain_done", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    for (int i = 0; i < N_DUT; i++) begin
      lv[i]    = 1'b0;
      msb_a[i] = 1'b0;
      din_a[i] = '0;
    end

    // Reset held two cycles with a word offered: nothing may be accepted.
    act   = 0;
    rst   = 1'b0;
    lv[0] = 1'b1;
    din_a[0] = 16'h000F;
    @(posedge clk);
    #1;
    mon_on = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b1;
    lv[0] = 1'b0;

    // LSB-first 1011 -> 1,1,0,1
    send_word(16'h000B, 1'b0, 0);
    drain();

    // MSB-first 1011 with a 3-cycle stall while the second bit is shown
    base = consumed;
    send_word(16'h000B, 1'b1, 0);
    wait_consumed(base + 1);
    @(posedge clk);
    #1;
    sen_dir = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    sen_dir = 1'b1;
    drain();

    // Back-to-back 8-bit words, opposite directions
    act = 1;
    send_word(16'h00A5, 1'b1, 0);
    send_word(16'h003C, 1'b0, 0);
    drain();

    // Mid-word reset, then a fresh word
    base = consumed;
    send_word(16'h00FF, 1'b1, 0);
    wait_consumed(base + 3);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    exp_q.delete();
    #1;
    rst = 1'b1;
    send_word(16'h0001, 1'b0, 0);
    drain();

    // din / msb_first churn during a word in flight
    act = 0;
    send_word(16'h0006, 1'b0, 0);
    repeat (4) begin
      din_a[0] = ~din_a[0];
      msb_a[0] = ~msb_a[0];
      @(posedge clk);
      #1;
    end
    drain();

    // Random regression with stalls and gaps
    rnd_stall = 1'b1;
    for (int a = 2; a < N_DUT; a++) begin
      act = a;
      repeat (25) begin
        send_word(16'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      end
      drain();
    end
    rnd_stall = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised parallel-in/serial-out shift register with a load handshake, per-word shift direction and a stallable serial output.
- Successor to the fixed 4-bit select-controlled PISO. Adds:
  - generic width;
  - valid/ready load;
  - bit counter with a last-bit flag;
  - LSB/MSB-first mode;
  - back-to-back gapless words.
- Sits between a parallel producer (register/FIFO) and a serial link or serialiser stage.

Parameters:
- WIDTH, 4, word width in bits; legal range WIDTH >= 2.
- IDLE_LEVEL, 1'b0, value driven on sout whenever sout_valid is 0.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on rising clk.
- load_valid  input  1  producer presents a word on din.
- load_ready  output  1  block can accept a word this cycle.
- din  input  WIDTH  parallel word, captured on load handshake.
- msb_first  input  1  direction for the word being loaded: 1 = bit WIDTH-1 first, 0 = bit 0 first; sampled only at load.
- shift_en  input  1  consumer takes the current serial bit this cycle; 0 = stall.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout carries a valid data bit.
- last  output  1  current bit is the final bit of the word.
- busy  output  1  a word is held or being shifted (equals sout_valid).

Behaviour:
- Reset (rst==0 at a posedge) has priority over every other input, including a mid-word reset. The word in flight is discarded, with no partial completion.
- Values after reset:
  - state IDLE, shift register 0, bit count 0, direction latch 0;
  - sout_valid 0, busy 0, last 0, sout IDLE_LEVEL, load_ready 1.
- States: IDLE and SHIFT. sout_valid = busy = (state==SHIFT).
- Bit counter: width $clog2(WIDTH), counts 0..WIDTH-1 and never wraps past WIDTH-1.
- IDLE:
  - load_ready = 1.
  - On load_valid & load_ready: capture din into the shift register, latch msb_first, clear count, go to SHIFT.
  - The first bit appears on sout in the cycle after acceptance (latency 1).
- SHIFT:
  - sout = shreg[WIDTH-1] if the latched direction is 1, else shreg[0]. This is a combinational select from registers.
  - last = (count == WIDTH-1).
  - shift_en=1: consume the bit.
    - Shift the register one place toward the output end, filling with 0.
    - count <= count+1.
  - shift_en=0: the register, count, sout and last all hold.
  - load_ready = last & shift_en. This is a combinational path from shift_en, and is intentional to allow zero-bubble streaming.
- End of word (shift_en & last at a posedge):
  - If load_valid is also 1: load the new word, latch the new msb_first and clear count. Stay in SHIFT with no idle cycle between words.
  - Otherwise: go to IDLE. sout_valid drops the next cycle.
- load_valid while in SHIFT and not at the final consumed bit:
  - Ignored; load_ready is 0.
  - The producer must hold din and load_valid until the handshake.
- msb_first and din changes are ignored outside the load handshake. A direction change never corrupts a word in flight.
- Throughput: one word per WIDTH cycles when shift_en stays high and load_valid is held.

Test Plan:
- WIDTH=4, rst low 2 cycles with load_valid=1 -> sout_valid=0, load_ready=1, sout=0, no load accepted; release and load din=4'b1011, msb_first=0, shift_en=1 -> sout sequence 1,1,0,1, last high on the 4th bit only, back to IDLE one cycle after.
- WIDTH=4, din=4'b1011, msb_first=1 -> sout sequence 1,0,1,1; shift_en low for 3 cycles after the 2nd bit -> sout=0 and count held; resumes with bits 1,1.
- WIDTH=8, back-to-back: word 8'hA5 (msb_first=1) then 8'h3C (msb_first=0) with load_valid held high -> 16 consecutive valid bits 1010_0101 then 0011_1100; sout_valid never drops; load_ready high only in cycles 8 and 16.
- WIDTH=8, load din=8'hFF, assert rst low after 3 bits -> next cycle sout_valid=0, busy=0, load_ready=1; a fresh load of 8'h01 (msb_first=0) yields 1,0,0,0,0,0,0,0.
- WIDTH=4, toggle msb_first and din every cycle during a word loaded as 4'b0110, msb_first=0 -> output stays 0,1,1,0.
- Random regression across WIDTH∈{2,5,16} with random stalls and load_valid -> scoreboard matches serialised words exactly; no bit lost or duplicated.
